// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller: register indices, CTRL bit
// positions and the VECTOR valid-bit position.
package irq_pkg;

    localparam logic [2:0] ADDR_PENDING   = 3'd0;
    localparam logic [2:0] ADDR_ENABLE    = 3'd1;
    localparam logic [2:0] ADDR_MODE      = 3'd2;
    localparam logic [2:0] ADDR_CTRL      = 3'd3;
    localparam logic [2:0] ADDR_VECTOR    = 3'd4;
    localparam logic [2:0] ADDR_INSERVICE = 3'd5;
    localparam logic [2:0] ADDR_EOI       = 3'd6;
    localparam logic [2:0] ADDR_RAW       = 3'd7;

    localparam int CTRL_GEN  = 0;
    localparam int CTRL_RR   = 1;
    localparam int VEC_VALID = 7;

    function automatic logic [7:0] onehot8(input logic [2:0] id);
        return 8'd1 << id;
    endfunction

endpackage

// File: rtl/irq_prio_sel.sv
// Rotating priority encoder: first set bit of cand at or after start,
// wrapping 7->0. id is 0 when nothing is set.
module irq_prio_sel (
    input  logic [7:0] cand,
    input  logic [2:0] start,
    output logic       valid,
    output logic [2:0] id
);

    logic [2:0] idx;

    always_comb begin
        valid = 1'b0;
        id    = 3'd0;
        idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = start + 3'(i);
            if (!valid && cand[idx]) begin
                valid = 1'b1;
                id    = idx;
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// 8-source interrupt controller with edge/level sources, nested fixed priority
// or round-robin arbitration, VECTOR-read acknowledge and EOI.
module irq_controller
    import irq_pkg::*;
#(
    parameter logic [7:0] ENABLE_DEFAULT = 8'h00,
    parameter bit         RR_DEFAULT     = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_phi2,
    input  logic       i_en,
    input  logic [2:0] i_addr,
    input  logic       i_rw,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    input  logic [7:0] i_src,
    output logic       o_irq
);

    logic       phi2_q;
    logic [7:0] src_q;
    logic [7:0] pending;
    logic [7:0] enable;
    logic [7:0] mode;
    logic [7:0] inservice;
    logic [1:0] ctrl;
    logic [2:0] rot_ptr;

    logic       strobe, wr, rd, ack;
    logic [7:0] cand, vector, w1c, mode_chg, rise, edge_clr, pending_nxt, below;
    logic [2:0] sel_start, win_id;
    logic       win_vld, irq_nxt;

    // One strobe per CPU cycle: rising phi2 as seen in the i_clk domain.
    assign strobe = i_en && i_phi2 && !phi2_q;
    assign wr     = strobe && !i_rw;
    assign rd     = strobe && i_rw;

    assign cand      = ctrl[CTRL_GEN] ? (pending & enable & ~inservice) : 8'h00;
    assign sel_start = ctrl[CTRL_RR] ? rot_ptr : 3'd0;

    irq_prio_sel u_sel (
        .cand  (cand),
        .start (sel_start),
        .valid (win_vld),
        .id    (win_id)
    );

    assign vector = {win_vld, 4'b0000, win_id};
    assign ack    = rd && (i_addr == ADDR_VECTOR) && win_vld;

    assign w1c      = (wr && i_addr == ADDR_PENDING) ? i_data : 8'h00;
    assign mode_chg = (wr && i_addr == ADDR_MODE) ? (i_data ^ mode) : 8'h00;
    assign rise     = i_src & ~src_q;
    assign edge_clr = w1c | (ack ? onehot8(win_id) : 8'h00);

    // Edge bits: set beats clear. Level bits track i_src. A MODE change wipes the bit.
    assign pending_nxt = ((mode & ((pending & ~edge_clr) | rise)) | (~mode & i_src)) & ~mode_chg;

    // Fixed mode nests: only a winner above every in-service level may interrupt.
    assign below   = onehot8(win_id) - 8'd1;
    assign irq_nxt = ctrl[CTRL_RR] ? (win_vld && inservice == 8'h00)
                                   : (win_vld && (inservice & below) == 8'h00);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            phi2_q    <= 1'b0;
            src_q     <= 8'h00;
            pending   <= 8'h00;
            enable    <= ENABLE_DEFAULT;
            mode      <= 8'h00;
            inservice <= 8'h00;
            ctrl      <= {RR_DEFAULT, 1'b0};
            rot_ptr   <= 3'd0;
            o_irq     <= 1'b0;
        end else begin
            phi2_q  <= i_phi2;
            src_q   <= i_src;
            pending <= pending_nxt;
            o_irq   <= irq_nxt;
            if (wr) begin
                case (i_addr)
                    ADDR_ENABLE: enable    <= i_data;
                    ADDR_MODE:   mode      <= i_data;
                    ADDR_CTRL:   ctrl      <= i_data[1:0];
                    ADDR_EOI:    inservice <= inservice & ~onehot8(i_data[2:0]);
                    default: ;
                endcase
            end
            if (ack) begin
                inservice <= inservice | onehot8(win_id);
                rot_ptr   <= win_id + 3'd1;
            end
        end
    end

    always_comb begin
        o_data = 8'h00;
        case (i_addr)
            ADDR_PENDING:   o_data = pending;
            ADDR_ENABLE:    o_data = enable;
            ADDR_MODE:      o_data = mode;
            ADDR_CTRL:      o_data = {6'b000000, ctrl};
            ADDR_VECTOR:    o_data = vector;
            ADDR_INSERVICE: o_data = inservice;
            ADDR_RAW:       o_data = i_src;
            default:        o_data = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: CPU-style register accesses on phi2,
// hand-computed expectations per scenario.
module tb_irq_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       phi2 = 1'b0;
    logic       en = 1'b0;
    logic [2:0] addr = 3'd0;
    logic       rw = 1'b1;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic [7:0] src = 8'h00;
    logic       irq;

    int total = 0;
    int bad = 0;

    irq_controller dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_phi2  (phi2),
        .i_en    (en),
        .i_addr  (addr),
        .i_rw    (rw),
        .i_data  (wdata),
        .o_data  (rdata),
        .i_src   (src),
        .o_irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Strobe lands on the second posedge; effects visible when the task returns.
    task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        en = 1'b1; rw = 1'b0; addr = a; wdata = d; phi2 = 1'b0;
        @(negedge clk);
        phi2 = 1'b1;
        @(negedge clk);
        phi2 = 1'b0; en = 1'b0; rw = 1'b1;
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        en = 1'b1; rw = 1'b1; addr = a; phi2 = 1'b0;
        @(negedge clk);
        phi2 = 1'b1;
        d = rdata;
        @(negedge clk);
        phi2 = 1'b0; en = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] m);
        @(negedge clk);
        src = src | m;
        @(negedge clk);
        src = src & ~m;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        do_reset();
        total++;
        if (irq !== 1'b0) begin
            bad++; $display("FAIL reset_irq got=%b exp=0", irq);
        end
        for (int i = 0; i < 8; i++) begin
            cpu_read(3'(i), d);
            total++;
            if (d !== 8'h00) begin
                bad++; $display("FAIL reset_reg%0d got=%h exp=00", i, d);
            end
        end
    endtask

    task automatic test_edge_basic();
        logic [7:0] d;
        cpu_write(3'd2, 8'hFF);
        cpu_write(3'd1, 8'h04);
        cpu_write(3'd3, 8'h01);
        cpu_read(3'd3, d);
        total++;
        if (d !== 8'h01) begin bad++; $display("FAIL ctrl_rb got=%h exp=01", d); end
        pulse(8'h04);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL edge_irq_lat1 got=%b exp=0", irq); end
        tick(1);
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL edge_irq_lat2 got=%b exp=1", irq); end
        cpu_read(3'd4, d);
        total++;
        if (d !== 8'h82) begin bad++; $display("FAIL edge_vector got=%h exp=82", d); end
        cpu_read(3'd0, d);
        total++;
        if (d !== 8'h00) begin bad++; $display("FAIL edge_pending got=%h exp=00", d); end
        cpu_read(3'd5, d);
        total++;
        if (d !== 8'h04) begin bad++; $display("FAIL edge_inservice got=%h exp=04", d); end
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL edge_irq_after_ack got=%b exp=0", irq); end
        cpu_write(3'd6, 8'hFA);
        cpu_read(3'd5, d);
        total++;
        if (d !== 8'h00) begin bad++; $display("FAIL eoi_upper_ignored got=%h exp=00", d); end
    endtask

    task automatic test_nesting();
        logic [7:0] d;
        cpu_write(3'd1, 8'h62);
        pulse(8'h20);
        tick(1);
        cpu_read(3'd4, d);
        total++;
        if (d !== 8'h85) begin bad++; $display("FAIL nest_vec5 got=%h exp=85", d); end
        pulse(8'h02);
        tick(1);
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL nest_irq1 got=%b exp=1", irq); end
        cpu_read(3'd4, d);
        total++;
        if (d !== 8'h81) begin bad++; $display("FAIL nest_vec1 got=%h exp=81", d); end
        pulse(8'h40);
        tick(2);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL nest_irq6_blocked got=%b exp=0", irq); end
        cpu_write(3'd6, 8'h05);
        tick(1);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL nest_irq6_after_eoi5 got=%b exp=0", irq); end
        cpu_read(3'd5, d);
        total++;
        if (d !== 8'h02) begin bad++; $display("FAIL nest_inservice got=%h exp=02", d); end
        cpu_write(3'd6, 8'h01);
        tick(1);
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL nest_irq6_after_eoi1 got=%b exp=1", irq); end
        cpu_read(3'd4, d);
        total++;
        if (d !== 8'h86) begin bad++; $display("FAIL nest_vec6 got=%h exp=86", d); end
        cpu_write(3'd6, 8'h06);
    endtask

    task automatic test_level();
        logic [7:0] d;
        cpu_write(3'd2, 8'hF7);
        cpu_write(3'd1, 8'h08);
        @(negedge clk);
        src = 8'h08;
        tick(2);
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL lvl_irq got=%b exp=1", irq); end
        cpu_read(3'd4, d);
        total++;
        if (d !== 8'h83) begin bad++; $display("FAIL lvl_vec got=%h exp=83", d); end
        tick(1);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL lvl_irq_in_service got=%b exp=0", irq); end
        cpu_read(3'd0, d);
        total++;
        if (d !== 8'h08) begin bad++; $display("FAIL lvl_pending_kept got=%h exp=08", d); end
        cpu_write(3'd6, 8'h03);
        tick(1);
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL lvl_irq_reassert got=%b exp=1", irq); end
        @(negedge clk);
        src = 8'h00;
        cpu_read(3'd0, d);
        total++;
        if (d !== 8'h00) begin bad++; $display("FAIL lvl_pending_drop got=%h exp=00", d); end
    endtask

    task automatic test_w1c_race();
        logic [7:0] d;
        cpu_write(3'd2, 8'hFF);
        pulse(8'h02);
        cpu_write(3'd0, 8'h02);
        cpu_read(3'd0, d);
        total++;
        if (d !== 8'h00) begin bad++; $display("FAIL w1c_plain got=%h exp=00", d); end
        @(negedge clk);
        en = 1'b1; rw = 1'b0; addr = 3'd0; wdata = 8'h02; phi2 = 1'b0;
        @(negedge clk);
        phi2 = 1'b1; src = 8'h02;
        @(negedge clk);
        phi2 = 1'b0; en = 1'b0; rw = 1'b1;
        cpu_read(3'd0, d);
        total++;
        if (d !== 8'h02) begin bad++; $display("FAIL w1c_set_wins got=%h exp=02", d); end
        src = 8'h00;
        cpu_write(3'd0, 8'h02);
    endtask

    task automatic test_round_robin();
        logic [7:0] d;
        logic [2:0] exp_id;
        do_reset();
        cpu_write(3'd1, 8'h11);
        cpu_write(3'd3, 8'h03);
        @(negedge clk);
        src = 8'h11;
        for (int k = 0; k < 4; k++) begin
            exp_id = (k % 2 == 0) ? 3'd0 : 3'd4;
            tick(2);
            total++;
            if (irq !== 1'b1) begin bad++; $display("FAIL rr_irq%0d got=%b exp=1", k, irq); end
            cpu_read(3'd4, d);
            total++;
            if (d !== {5'b10000, exp_id}) begin
                bad++; $display("FAIL rr_vec%0d got=%h exp=%h", k, d, {5'b10000, exp_id});
            end
            cpu_write(3'd6, {5'b00000, exp_id});
        end
        @(negedge clk);
        src = 8'h00;
        cpu_write(3'd3, 8'h00);
    endtask

    task automatic test_reset_mid_service();
        logic [7:0] d;
        cpu_write(3'd2, 8'hFF);
        cpu_write(3'd1, 8'hFF);
        cpu_write(3'd3, 8'h01);
        pulse(8'h10);
        tick(1);
        cpu_read(3'd4, d);
        total++;
        if (d !== 8'h84) begin bad++; $display("FAIL rst_setup_vec got=%h exp=84", d); end
        pulse(8'h03);
        cpu_read(3'd0, d);
        total++;
        if (d !== 8'h03) begin bad++; $display("FAIL rst_setup_pending got=%h exp=03", d); end
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL rst_setup_irq got=%b exp=1", irq); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b exp=0", irq); end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cpu_read(3'(i), d);
            total++;
            if (d !== 8'h00) begin
                bad++; $display("FAIL rst_mid_reg%0d got=%h exp=00", i, d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_edge_basic();
        test_nesting();
        test_level();
        test_w1c_race();
        test_round_robin();
        test_reset_mid_service();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
